// File: rtl/mips_mc_sequencer.sv
// Multi-cycle ID/EX/MEM/WB sequencer for the MIPS core.
// Clears the register file and data memory in hardware after reset.
module mips_mc_sequencer #(
    parameter int REG_COUNT   = 32,
    parameter int MEM_DEPTH   = 128,
    parameter int ADDR_W      = 7,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr_word,
    output logic              instr_ready,
    input  logic              flush,
    input  logic              mem_ack,
    output logic [31:0]       instr_q,
    output logic              id_en,
    output logic              ex_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              retire,
    output logic              illegal,
    output logic              mem_timeout,
    output logic              clr_rf_we,
    output logic              clr_mem_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_done,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST =
        (MEM_TIMEOUT > 0) ? TW'(MEM_TIMEOUT - 1) : '0;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   RF_END   = (ADDR_W + 1)'(REG_COUNT);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_ID, S_EX, S_MEM, S_WB
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] stall_cnt;
    logic          legal, has_mem, has_wb;
    logic          clr_last, tmo_hit;
    logic          retire_nx, illegal_nx, tmo_nx;

    always_comb begin
        legal   = 1'b1;
        has_mem = 1'b0;
        has_wb  = 1'b0;
        case (instr_q[31:26])
            6'b000000, 6'b001000: has_wb = 1'b1;
            6'b100011: begin
                has_mem = 1'b1;
                has_wb  = 1'b1;
            end
            6'b101011: has_mem = 1'b1;
            6'b000100: legal = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

    assign clr_last = (state == S_INIT) && (clr_addr == CLR_LAST);
    assign tmo_hit  = (MEM_TIMEOUT != 0) && (stall_cnt == TMO_LAST);

    // flush outranks every other exit from a busy stage
    always_comb begin
        state_nx   = state;
        retire_nx  = 1'b0;
        illegal_nx = 1'b0;
        tmo_nx     = 1'b0;
        case (state)
            S_INIT: if (clr_last) state_nx = S_IDLE;
            S_IDLE: if (instr_valid) state_nx = S_ID;
            S_ID: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (legal) begin
                    state_nx = S_EX;
                end else begin
                    state_nx   = S_IDLE;
                    illegal_nx = 1'b1;
                end
            end
            S_EX: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (has_mem) begin
                    state_nx = S_MEM;
                end else if (has_wb) begin
                    state_nx = S_WB;
                end else begin
                    state_nx  = S_IDLE;
                    retire_nx = 1'b1;
                end
            end
            S_MEM: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (mem_ack) begin
                    if (has_wb) begin
                        state_nx = S_WB;
                    end else begin
                        state_nx  = S_IDLE;
                        retire_nx = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_nx = S_IDLE;
                    tmo_nx   = 1'b1;
                end
            end
            S_WB: begin
                state_nx  = S_IDLE;
                retire_nx = !flush;
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_INIT;
            instr_q     <= '0;
            clr_addr    <= '0;
            init_done   <= 1'b0;
            stall_cnt   <= '0;
            retire      <= 1'b0;
            illegal     <= 1'b0;
            mem_timeout <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state       <= state_nx;
            retire      <= retire_nx;
            illegal     <= illegal_nx;
            mem_timeout <= tmo_nx;
            if (retire_nx)
                retired_cnt <= retired_cnt + CNT_W'(1);
            if (state == S_IDLE && instr_valid)
                instr_q <= instr_word;
            if (state == S_INIT) begin
                clr_addr <= clr_last ? '0 : clr_addr + ADDR_W'(1);
                if (clr_last)
                    init_done <= 1'b1;
            end
            if (state == S_MEM && !mem_ack)
                stall_cnt <= stall_cnt + TW'(1);
            else
                stall_cnt <= '0;
        end
    end

    assign instr_ready = (state == S_IDLE);
    assign id_en       = (state == S_ID);
    assign ex_en       = (state == S_EX);
    assign mem_en      = (state == S_MEM);
    assign wb_en       = (state == S_WB);
    // the sweep strobes are decoded from INIT, so mask them while reset is held
    assign clr_mem_we  = (state == S_INIT) && !reset;
    assign clr_rf_we   = clr_mem_we && ({1'b0, clr_addr} < RF_END);

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Bench for mips_mc_sequencer: clear sweep, directed vectors,
// reset mid-instruction and randomized traffic against a stage-list model.
module tb_mips_mc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic        instr_ready;
    logic        flush;
    logic        mem_ack;
    logic [31:0] instr_q;
    logic        id_en, ex_en, mem_en, wb_en;
    logic        retire, illegal, mem_timeout;
    logic        clr_rf_we, clr_mem_we;
    logic [6:0]  clr_addr;
    logic        init_done;
    logic [15:0] retired_cnt;

    always #5 clock = ~clock;

    mips_mc_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_word  (instr_word),
        .instr_ready (instr_ready),
        .flush       (flush),
        .mem_ack     (mem_ack),
        .instr_q     (instr_q),
        .id_en       (id_en),
        .ex_en       (ex_en),
        .mem_en      (mem_en),
        .wb_en       (wb_en),
        .retire      (retire),
        .illegal     (illegal),
        .mem_timeout (mem_timeout),
        .clr_rf_we   (clr_rf_we),
        .clr_mem_we  (clr_mem_we),
        .clr_addr    (clr_addr),
        .init_done   (init_done),
        .retired_cnt (retired_cnt)
    );

    int passed = 0;
    int total  = 0;
    int cnt_exp;

    typedef struct {
        logic [31:0] word;
        int          ack_at;
        int          flush_at;
        string       seq;
        string       fin;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    function automatic logic [3:0] en_of(input byte c);
        case (c)
            "I":     return 4'b1000;
            "E":     return 4'b0100;
            "M":     return 4'b0010;
            "W":     return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"},
            64'({instr_ready, id_en, ex_en, mem_en, wb_en, retire, illegal,
                 mem_timeout, clr_mem_we, clr_rf_we, init_done, clr_addr}),
            64'd0);
        chk({tag, "_data"}, {instr_q, 16'd0, retired_cnt}, 64'd0);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 128; i++) begin
            chk($sformatf("%s_c%0d", tag, i),
                64'({clr_mem_we, clr_rf_we, init_done, instr_ready, clr_addr}),
                64'({1'b1, (i < 32), 1'b0, 1'b0, 7'(i)}));
            flush = (i % 3 == 0);
            tick;
        end
        flush = 1'b0;
        chk({tag, "_done"},
            64'({clr_mem_we, clr_rf_we, init_done, instr_ready, clr_addr}),
            64'({4'b0011, 7'd0}));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        instr_valid = 1'b1;
        instr_word  = v.word;
        chk($sformatf("v%0d_ready", idx), 64'(instr_ready), 64'd1);
        tick;
        instr_valid = 1'b0;
        for (int k = 1; k <= v.seq.len(); k++) begin
            chk($sformatf("v%0d_c%0d", idx, k),
                64'({instr_ready, id_en, ex_en, mem_en, wb_en}),
                64'({1'b0, en_of(v.seq[k-1])}));
            mem_ack = (k == v.ack_at);
            flush   = (k == v.flush_at);
            tick;
        end
        mem_ack = 1'b0;
        flush   = 1'b0;
        if (v.fin == "R") cnt_exp++;
        chk($sformatf("v%0d_end", idx),
            64'({instr_ready, id_en, ex_en, mem_en, wb_en,
                 retire, illegal, mem_timeout}),
            64'({5'b10000, v.fin == "R", v.fin == "X", v.fin == "T"}));
        chk($sformatf("v%0d_cnt", idx), 64'(retired_cnt), 64'(cnt_exp[15:0]));
        chk($sformatf("v%0d_iq", idx), 64'(instr_q), 64'(v.word));
    endtask

    // reference model: list of stages still to run for the current word
    int          q[$];
    bit          ill;
    int          stall;
    logic [31:0] mq;
    int          cnt;
    bit          pr, pi, pt;

    task automatic load(input logic [5:0] op);
        q.delete();
        ill = 1'b0;
        q.push_back(1);
        case (op)
            6'h00, 6'h08: begin q.push_back(2); q.push_back(4); end
            6'h23: begin q.push_back(2); q.push_back(3); q.push_back(4); end
            6'h2B: begin q.push_back(2); q.push_back(3); end
            6'h04: q.push_back(2);
            default: ill = 1'b1;
        endcase
    endtask

    task automatic model_step;
        pr = 0; pi = 0; pt = 0;
        if (q.size() == 0) begin
            if (instr_valid) begin
                mq = instr_word;
                load(instr_word[31:26]);
            end
        end else if (flush) begin
            q.delete();
            stall = 0;
        end else if (q[0] == 3 && !mem_ack) begin
            stall++;
            if (stall == 15) begin
                q.delete();
                stall = 0;
                pt = 1;
            end
        end else begin
            void'(q.pop_front());
            stall = 0;
            if (q.size() == 0) begin
                if (ill) pi = 1;
                else begin
                    pr = 1;
                    cnt++;
                end
            end
        end
    endtask

    initial begin
        logic [5:0]  ops[7];
        int          pcts[3];
        int          ack_pct;
        logic [31:0] r;

        ops  = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F, 6'h01};
        pcts = '{5, 40, 90};
        ack_pct = 5;

        tbl[0]  = '{32'h012A4020, 0, 0, "IEW", "R"};
        tbl[1]  = '{32'h8D090004, 6, 0, "IEMMMMW", "R"};
        tbl[2]  = '{32'hAD090004, 3, 0, "IEM", "R"};
        tbl[3]  = '{32'h11090004, 0, 0, "IE", "R"};
        tbl[4]  = '{32'h21090004, 0, 0, "IEW", "R"};
        tbl[5]  = '{32'hFC000000, 0, 0, "I", "X"};
        tbl[6]  = '{32'h8D090004, 0, 0, "IEMMMMMMMMMMMMMMM", "T"};
        tbl[7]  = '{32'h8D090004, 3, 0, "IEMW", "R"};
        tbl[8]  = '{32'h8D090004, 4, 4, "IEMM", "F"};
        tbl[9]  = '{32'h012A4020, 0, 2, "IE", "F"};
        tbl[10] = '{32'h012A4020, 0, 3, "IEW", "F"};

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr_word  = '0;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        tick;
        tick;
        chk_reset("reset");
        reset = 1'b0;
        #1;
        sweep("init");

        cnt_exp = 0;
        for (int i = 0; i < 11; i++) run_vec(tbl[i], i);

        instr_valid = 1'b1;
        instr_word  = 32'h012A4020;
        tick;
        instr_valid = 1'b0;
        tick;
        chk("midex_ex", 64'({id_en, ex_en, mem_en, wb_en}), 64'(4'b0100));
        reset = 1'b1;
        #1;
        chk_reset("midex_reset");
        tick;
        reset = 1'b0;
        #1;
        sweep("reinit");

        q.delete();
        ill = 0; stall = 0; mq = '0; cnt = 0;
        pr = 0; pi = 0; pt = 0;
        for (int c = 0; c < 4000; c++) begin
            int h;
            h = (q.size() != 0) ? q[0] : 0;
            chk($sformatf("rand_c%0d", c),
                64'({clr_mem_we, clr_rf_we, init_done,
                     instr_ready, id_en, ex_en, mem_en, wb_en,
                     retire, illegal, mem_timeout, instr_q, retired_cnt}),
                64'({3'b001, q.size() == 0, h == 1, h == 2, h == 3, h == 4,
                     pr, pi, pt, mq, cnt[15:0]}));
            if (c % 500 == 0) ack_pct = pcts[(c / 500) % 3];
            r = $urandom;
            instr_valid = r[31];
            instr_word  = {ops[$urandom % 7], r[25:0]};
            flush       = ($urandom % 12 == 0);
            mem_ack     = ($urandom % 100 < ack_pct);
            model_step;
            tick;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
